// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: default widths, entry layout
// and the saturation constant used for overflowed results.
package result_collector_pkg;

    // Default result width, address width and final-result address.
    localparam int RC_N         = 32;
    localparam int RC_M         = 3;
    localparam int RC_LAST_ADDR = (1 << RC_M) - 1;

    // One stored entry is {of, addr, y}.
    function automatic int entry_width(input int n, input int m);
        return n + m + 1;
    endfunction

    // Largest positive two's-complement value of an n-bit result (n <= 64).
    function automatic logic [63:0] sat_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/result_collector_sync_fifo.sv
// Small register-based FIFO with wrap-bit pointers. The head entry is read
// combinationally so a pushed entry is visible right after its write edge.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [W-1:0] slot_view [DEPTH];

    // One storage register per slot; entries reset to zero so an empty FIFO
    // presents a well-defined all-zero head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [W-1:0] slot_reg;

            // Capture write data when this slot is the write target.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (push && !clr && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    slot_reg <= wdata;
                end
            end

            assign slot_view[gi] = slot_reg;
        end
    endgenerate

    // Pointer update; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rdata = slot_view[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/result_collector.sv
// Sink of the series-evaluation pipeline: buffers results, stalls the
// pipeline when the buffer is full, and hands results downstream.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int N         = RC_N,
    parameter int M         = RC_M,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16,
    parameter int LAST_ADDR = RC_LAST_ADDR,
    parameter int SATURATE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             valid_flag_in,
    input  logic             of_flag_in,
    input  logic [N-1:0]     y_in,
    input  logic [M-1:0]     addr_in,
    output logic             pipe_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_y,
    output logic [M-1:0]     out_addr,
    output logic             out_of,
    output logic             out_last,
    output logic             of_sticky,
    output logic [CNT_W-1:0] result_cnt,
    output logic             done
);

    localparam int            EW       = entry_width(N, M);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [63:0]   SAT_WIDE = sat_max(N);
    localparam logic [N-1:0]  SAT_VAL  = SAT_WIDE[N-1:0];

    logic [EW-1:0]    head;
    logic [AW:0]      fifo_count;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             head_of;
    logic [M-1:0]     head_addr;
    logic [N-1:0]     head_y;
    logic             of_sticky_reg;
    logic [CNT_W-1:0] result_cnt_reg;
    logic             done_reg;

    sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata ({of_flag_in, addr_in, y_in}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full)
    );

    // The pipeline only advances while there is room, so every result it
    // presents while enabled is captured exactly once.
    assign pipe_en   = !fifo_full;
    assign out_valid = (fifo_count != '0);
    assign push      = pipe_en && valid_flag_in && !clr;
    assign pop       = out_valid && out_ready && !clr;

    assign head_of   = head[EW-1];
    assign head_addr = head[N+M-1:N];
    assign head_y    = head[N-1:0];

    assign out_y      = ((SATURATE != 0) && head_of) ? SAT_VAL : head_y;
    assign out_addr   = head_addr;
    assign out_of     = head_of;
    assign out_last   = (head_addr == M'(LAST_ADDR));
    assign of_sticky  = of_sticky_reg;
    assign result_cnt = result_cnt_reg;
    assign done       = done_reg;

    // Status: sticky overflow, popped-result count and end-of-computation pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_sticky_reg  <= 1'b0;
            result_cnt_reg <= '0;
            done_reg       <= 1'b0;
        end else if (clr) begin
            of_sticky_reg  <= 1'b0;
            result_cnt_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            if (push && of_flag_in) begin
                of_sticky_reg <= 1'b1;
            end
            if (pop) begin
                result_cnt_reg <= result_cnt_reg + 1'b1;
            end
            done_reg <= pop && out_last;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Randomised bench for result_collector with a queue-based reference model
// and a monitor that checks the DUT every cycle against that model.
module tb_result_collector;

    localparam int N         = 32;
    localparam int M         = 3;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 16;
    localparam int LAST_ADDR = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             valid_flag_in = 1'b0;
    logic             of_flag_in = 1'b0;
    logic [N-1:0]     y_in = '0;
    logic [M-1:0]     addr_in = '0;
    logic             out_ready = 1'b0;
    logic             pipe_en;
    logic             out_valid;
    logic [N-1:0]     out_y;
    logic [M-1:0]     out_addr;
    logic             out_of;
    logic             out_last;
    logic             of_sticky;
    logic [CNT_W-1:0] result_cnt;
    logic             done;

    result_collector #(
        .N(N), .M(M), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .LAST_ADDR(LAST_ADDR), .SATURATE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .valid_flag_in(valid_flag_in), .of_flag_in(of_flag_in),
        .y_in(y_in), .addr_in(addr_in), .pipe_en(pipe_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_addr(out_addr), .out_of(out_of), .out_last(out_last),
        .of_sticky(of_sticky), .result_cnt(result_cnt), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] y;
        logic [M-1:0] a;
        logic         of;
    } ent_t;

    ent_t exp_q[$];
    int   exp_cnt = 0;
    bit   exp_sticky = 0;
    bit   exp_done = 0;
    bit   accepted = 0;
    int   mode = 0;   // 0: out_ready low, 1: high, 2: random
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: a bounded queue of results in arrival order.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0; exp_sticky = 0; exp_done = 0; accepted = 0;
        end else begin
            bit room, take, give;
            room = exp_q.size() < DEPTH;
            take = room && valid_flag_in && !clr;
            give = (exp_q.size() != 0) && out_ready && !clr;
            if (clr) begin
                exp_q.delete();
                exp_cnt = 0; exp_sticky = 0; exp_done = 0;
                accepted = room && valid_flag_in;   // stage advanced, result dropped
            end else begin
                exp_done = 0;
                if (give) begin
                    ent_t e;
                    e = exp_q.pop_front();
                    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                    exp_done = (e.a == LAST_ADDR);
                end
                if (take) begin
                    ent_t n;
                    n.y = y_in; n.a = addr_in; n.of = of_flag_in;
                    exp_q.push_back(n);
                    if (of_flag_in) exp_sticky = 1;
                end
                accepted = take;
            end
        end
    end

    // Monitor: compares the presented outputs with the model each cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("pipe_en", pipe_en, (exp_q.size() < DEPTH));
            chk("out_valid", out_valid, (exp_q.size() != 0));
            chk("result_cnt", result_cnt, exp_cnt);
            chk("of_sticky", of_sticky, exp_sticky);
            chk("done", done, exp_done);
            if (exp_q.size() != 0) begin
                logic [N-1:0] ey;
                ey = exp_q[0].of ? 32'h7FFF_FFFF : exp_q[0].y;
                chk("out_y", out_y, ey);
                chk("out_addr", out_addr, exp_q[0].a);
                chk("out_of", out_of, exp_q[0].of);
                chk("out_last", out_last, (exp_q[0].a == LAST_ADDR));
            end
        end
    end

    // Downstream ready generator.
    initial forever begin
        @(negedge clk);
        #1;
        case (mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Present one result and hold it until the pipeline would advance.
    task automatic send(input logic [N-1:0] y, input logic [M-1:0] a, input logic of);
        int guard;
        @(negedge clk);
        #2;
        valid_flag_in = 1'b1; y_in = y; addr_in = a; of_flag_in = of;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!accepted && guard < 100);
        if (!accepted) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=%0d required=accept", guard);
        end
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        #2;
        valid_flag_in = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pipe_en", pipe_en, 1);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_of", out_of, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_result_cnt", result_cnt, 0);
        chk("rst_of_sticky", of_sticky, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: addr 0..7 with downstream always ready
        mode = 1;
        for (int a = 0; a < 8; a++) send(N'(100 + a), M'(a), 1'b0);
        idle(4);
        chk("stream_cnt", result_cnt, 8);

        // Backpressure: fifth result held until space opens
        mode = 0;
        fork
            for (int i = 0; i < 5; i++) send(N'(200 + i), M'(i), 1'b0);
            begin
                repeat (8) @(negedge clk);
                mode = 1;
            end
        join
        idle(6);

        // Overflowed result is saturated; sticky flag persists after pop
        send(32'h1234_5678, 3'd3, 1'b1);
        idle(4);
        chk("sticky_after_pop", of_sticky, 1);

        // Random traffic with wrap-around
        mode = 2;
        for (int i = 0; i < 60; i++) begin
            send($urandom, M'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end
        mode = 1;
        idle(8);

        // clr with a simultaneous push and pop
        mode = 0;
        send(32'd11, 3'd1, 1'b1);
        send(32'd12, 3'd2, 1'b0);
        send(32'd13, 3'd3, 1'b0);
        @(negedge clk);
        #2;
        mode = 1;
        clr = 1'b1; valid_flag_in = 1'b1; y_in = 32'd99; addr_in = 3'd7; of_flag_in = 1'b1;
        @(negedge clk);
        #2;
        clr = 1'b0; valid_flag_in = 1'b0;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_result_cnt", result_cnt, 0);
        chk("clr_of_sticky", of_sticky, 0);
        idle(3);

        // Asynchronous reset while full
        mode = 0;
        for (int i = 0; i < 4; i++) send(N'(300 + i), M'(i), 1'b1);
        idle(2);
        chk("full_pipe_en", pipe_en, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_pipe_en", pipe_en, 1);
        chk("arst_of_sticky", of_sticky, 0);
        chk("arst_result_cnt", result_cnt, 0);
        chk("arst_out_y", out_y, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Traffic resumes cleanly after reset
        mode = 2;
        for (int i = 0; i < 12; i++) send($urandom, M'(i % 8), 1'b0);
        mode = 1;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Sink end of the series-evaluation pipeline.
- Captures each valid result leaving the last pipeline stage (y, addr, overflow flag) into a small FIFO.
- Presents results downstream over a ready/valid handshake.
- Drives the pipeline stage enable, stalling the pipeline when the FIFO cannot accept, so no result is lost or duplicated.

Parameters:
- N, 32, result (y) width
- M, 3, address/term-index width
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_W, 16, width of popped-result counter
- LAST_ADDR, 7, address marking the final result of a computation
- SATURATE, 1, 1 = replace y of overflowed results with max positive value

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear: empties FIFO, clears counter and sticky flag
- valid_flag_in  input  1  last pipeline stage holds a valid result
- of_flag_in  input  1  overflow flag of that result
- y_in  input  N  result value
- addr_in  input  M  result address
- pipe_en  output  1  enable to all pipeline stage registers
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts head
- out_y  output  N  head result, saturated if enabled
- out_addr  output  M  head address
- out_of  output  1  head overflow flag
- out_last  output  1  head addr == LAST_ADDR
- of_sticky  output  1  any accepted result had overflow since reset/clr
- result_cnt  output  CNT_W  number of results popped
- done  output  1  one-cycle pulse on pop of a LAST_ADDR entry

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty; read/write pointers 0.
  - out_valid = 0; of_sticky = 0; result_cnt = 0; done = 0.
  - pipe_en = 1 (combinational from empty count).
  - out_y/out_addr/out_of/out_last reflect empty storage: zeroed entries, so 0, 0, 0, and (LAST_ADDR==0).
- pipe_en = (count < DEPTH). Purely combinational from registered count; no combinational path from out_ready.
- Push:
  - Occurs on a clk edge with pipe_en && valid_flag_in && !clr.
  - Stores {of_flag_in, addr_in, y_in} at the write pointer.
  - Because the pipeline advances only when pipe_en is high, each result is captured exactly once. When pipe_en is low, the stage output is held and is not pushed.
- Pop:
  - Occurs on a clk edge with out_valid && out_ready && !clr; advances the read pointer.
- Latency: result accepted at edge k is visible at out_* after edge k (out_valid high in cycle k+1). No bypass.
- Empty + push: no pop that cycle.
- Full + out_ready: pop only, since pipe_en = 0. pipe_en rises the following cycle.
- Push and pop in the same cycle (0 < count < DEPTH): count unchanged.
- Count range 0..DEPTH. Pointers are log2(DEPTH)+1 bits with a wrap bit; full = MSBs differ and LSBs equal.
- Outputs:
  - out_valid = (count != 0).
  - out_y = (SATURATE && head.of) ? {1'b0, {N-1{1'b1}}} : head.y.
  - out_of and out_addr are raw head fields.
- of_sticky: set on any push with of_flag_in = 1; cleared only by clr/reset.
- result_cnt: +1 per pop; wraps modulo 2^CNT_W.
- done: registered; high the cycle after popping an entry whose addr == LAST_ADDR.
- clr:
  - Has priority over push and pop in the same cycle; the push/pop is discarded.
  - Empties FIFO, zeroes result_cnt, clears of_sticky, clears done.
- Reset mid-operation: all state cleared immediately; pending entries lost.

Decomposition:
- Shared package holds:
  - Entry layout widths (N, M, entry width = N+M+1).
  - Saturation constant SAT_MAX(N).
  - Default LAST_ADDR = 2^M-1.
- One natural sub-module: sync_fifo (parameterised width/depth, count, full/empty). The collector adds enable generation, saturation, counters and flags around it.

Test Plan:
- Reset, then 8 consecutive valid results addr 0..7, y = 100+addr, out_ready = 1 → 8 pops in order, out_y 100..107, done pulse after addr 7, result_cnt = 8, pipe_en never low.
- out_ready = 0, 5 valid inputs → 4 pushed, pipe_en low after 4th edge, 5th held. Raise out_ready → entries popped in order; 5th accepted the cycle pipe_en returns high. No loss or duplication.
- Push with of_flag_in = 1, y_in = 0x12345678, SATURATE = 1 → out_y = 0x7FFFFFFF, out_of = 1, of_sticky = 1 and stays 1 after pop.
- FIFO at count 2, simultaneous push and pop → count stays 2, order preserved across pointer wrap (run 3×DEPTH entries).
- FIFO holding 3 entries, assert clr together with valid_flag_in and out_ready → next cycle out_valid = 0, result_cnt = 0, of_sticky = 0, input not stored.
- Drop rst_n asynchronously between clock edges while full → outputs clear before the next edge, pipe_en = 1.
